// File: rtl/parallel_axis_frame_capture.sv
// Multi-frame AXIS capture sink: tlast alignment, frame-length checking, skip/decimation,
// one-shot or ring storage, and a synchronous read-first readback port.
module parallel_axis_frame_capture #(
  parameter int SAMP_PER_CLK = 2,
  parameter int SAMP_WIDTH   = 32,
  parameter int TUSER        = 8,
  parameter int FRAME_BEATS  = 8,
  parameter int FRAMES       = 2,
  localparam int DEPTH       = FRAMES * FRAME_BEATS,
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [SAMP_PER_CLK*SAMP_WIDTH-1:0] s_axis_tdata,
  input  logic                             s_axis_tvalid,
  output logic                             s_axis_tready,
  input  logic                             s_axis_tlast,
  input  logic [TUSER-1:0]                 s_axis_tuser,
  input  logic                             cfg_arm,
  input  logic                             cfg_stop,
  input  logic                             cfg_ring,
  input  logic [15:0]                      cfg_skip,
  input  logic [7:0]                       cfg_decim,
  input  logic                             rd_en,
  input  logic [AW-1:0]                    rd_addr,
  output logic [SAMP_PER_CLK*SAMP_WIDTH-1:0] rd_data,
  output logic [TUSER-1:0]                 rd_user,
  output logic                             rd_valid,
  output logic                             busy,
  output logic                             full,
  output logic                             done,
  output logic [15:0]                      frames_captured,
  output logic                             err_len
);

  localparam int DW = SAMP_PER_CLK * SAMP_WIDTH;
  localparam int BW = $clog2(FRAME_BEATS);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_SKIP, S_CAPTURE, S_DONE} state_t;
  state_t state, state_n;

  logic            tready_r, ring_l, stop_pend, full_r, err_r;
  logic [AW-1:0]   wptr, frame_base, next_slot;
  logic [BW-1:0]   beat_cnt;
  logic [15:0]     skip_l, skip_cnt, fc;
  logic [7:0]      decim_l, decim_cnt;
  logic            beat, at_last, good_end, early_end, miss_end;
  logic            wr_frame, commit, stop_eff, slot_last;
  logic [TUSER+DW-1:0] mem [DEPTH];

  always_comb begin
    beat      = s_axis_tvalid && tready_r;
    at_last   = (beat_cnt == BW'(FRAME_BEATS - 1));
    good_end  = beat && s_axis_tlast && at_last;
    early_end = beat && s_axis_tlast && !at_last;
    miss_end  = beat && !s_axis_tlast && at_last;
    wr_frame  = (state == S_CAPTURE) && (decim_cnt == '0);
    commit    = wr_frame && good_end;
    stop_eff  = ring_l && (stop_pend || cfg_stop);
    slot_last = (frame_base == AW'(DEPTH - FRAME_BEATS));
    next_slot = slot_last ? '0 : frame_base + AW'(FRAME_BEATS);
    state_n   = state;
    if (cfg_arm) begin
      state_n = S_SYNC;
    end else begin
      unique case (state)
        S_SYNC:
          if (beat && s_axis_tlast) state_n = (skip_l != '0) ? S_SKIP : S_CAPTURE;
        S_SKIP:
          if (miss_end) state_n = S_SYNC;
          else if (good_end && skip_cnt == skip_l - 16'd1) state_n = S_CAPTURE;
        S_CAPTURE:
          // A pending ring stop ends at whatever closes the current frame, good or bad.
          if (good_end || early_end || miss_end) begin
            if (stop_eff) state_n = S_DONE;
            else if (miss_end) state_n = S_SYNC;
            else if (commit && !ring_l && fc == 16'(FRAMES - 1)) state_n = S_DONE;
          end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tready_r   <= 1'b0;
      ring_l     <= 1'b0;
      stop_pend  <= 1'b0;
      full_r     <= 1'b0;
      err_r      <= 1'b0;
      wptr       <= '0;
      frame_base <= '0;
      beat_cnt   <= '0;
      skip_l     <= '0;
      skip_cnt   <= '0;
      decim_l    <= '0;
      decim_cnt  <= '0;
      fc         <= '0;
    end else begin
      tready_r <= 1'b1;
      if (cfg_arm) begin
        ring_l     <= cfg_ring;
        skip_l     <= cfg_skip;
        decim_l    <= cfg_decim;
        stop_pend  <= 1'b0;
        full_r     <= 1'b0;
        err_r      <= 1'b0;
        wptr       <= '0;
        frame_base <= '0;
        beat_cnt   <= '0;
        skip_cnt   <= '0;
        decim_cnt  <= '0;
        fc         <= '0;
      end else begin
        if (state == S_CAPTURE && ring_l && cfg_stop) stop_pend <= 1'b1;
        if (state == S_SYNC && beat && s_axis_tlast) begin
          beat_cnt  <= '0;
          skip_cnt  <= '0;
          decim_cnt <= '0;
        end
        if ((state == S_SKIP || state == S_CAPTURE) && beat) begin
          beat_cnt <= (s_axis_tlast || at_last) ? '0 : beat_cnt + 1'b1;
          if (early_end || miss_end) err_r <= 1'b1;
          if (state == S_SKIP && good_end) skip_cnt <= skip_cnt + 16'd1;
          if (state == S_CAPTURE) begin
            if (good_end) decim_cnt <= (decim_cnt == decim_l) ? '0 : decim_cnt + 8'd1;
            if (wr_frame) begin
              if (commit) begin
                wptr       <= next_slot;
                frame_base <= next_slot;
                fc         <= fc + 16'd1;
                if (slot_last) full_r <= 1'b1;
              end else if (early_end || miss_end) begin
                wptr <= frame_base;
              end else begin
                wptr <= wptr + 1'b1;
              end
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!cfg_arm && wr_frame && beat) mem[wptr] <= {s_axis_tuser, s_axis_tdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_user  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) {rd_user, rd_data} <= mem[rd_addr];
    end
  end

  assign s_axis_tready   = tready_r;
  assign busy            = (state == S_SYNC) || (state == S_SKIP) || (state == S_CAPTURE);
  assign done            = (state == S_DONE);
  assign full            = full_r;
  assign frames_captured = fc;
  assign err_len         = err_r;

endmodule

// File: tb/tb_parallel_axis_frame_capture.sv
// Directed bench for parallel_axis_frame_capture with default geometry (8-beat frames, 2 frames).
module tb_parallel_axis_frame_capture;

  localparam int SPC = 2;
  localparam int SW  = 32;
  localparam int TU  = 8;
  localparam int FB  = 8;
  localparam int FR  = 2;
  localparam int DW  = SPC * SW;
  localparam int AW  = $clog2(FB * FR);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] s_axis_tdata;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [TU-1:0] s_axis_tuser;
  logic          cfg_arm, cfg_stop, cfg_ring;
  logic [15:0]   cfg_skip;
  logic [7:0]    cfg_decim;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [TU-1:0] rd_user;
  logic          rd_valid, busy, full, done, err_len;
  logic [15:0]   frames_captured;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit tready_drop = 1'b0;

  parallel_axis_frame_capture #(
    .SAMP_PER_CLK(SPC), .SAMP_WIDTH(SW), .TUSER(TU), .FRAME_BEATS(FB), .FRAMES(FR)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .cfg_arm(cfg_arm), .cfg_stop(cfg_stop), .cfg_ring(cfg_ring), .cfg_skip(cfg_skip),
    .cfg_decim(cfg_decim), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_user(rd_user), .rd_valid(rd_valid), .busy(busy), .full(full), .done(done),
    .frames_captured(frames_captured), .err_len(err_len)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mon_en && !s_axis_tready) tready_drop = 1'b1;

  function automatic logic [DW-1:0] bdata(input int v);
    return {32'(v) + 32'h1000, 32'(v)};
  endfunction

  function automatic logic [TU-1:0] buser(input int v);
    return 8'(v) ^ 8'h5A;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // packs {busy, full, done, err_len, frames_captured}
  task automatic check_status(input string tag, input logic b, input logic f, input logic d,
                              input logic e, input logic [15:0] n);
    check(tag, {busy, full, done, err_len, frames_captured}, {b, f, d, e, n});
  endtask

  task automatic idle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_arm       = 1'b0;
    cfg_stop      = 1'b0;
    rd_en         = 1'b0;
  endtask

  task automatic beat(input logic [DW-1:0] d, input logic [TU-1:0] u, input logic last);
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tuser  = u;
    s_axis_tlast  = last;
    cfg_arm       = 1'b0;
    cfg_stop      = 1'b0;
    rd_en         = 1'b0;
  endtask

  task automatic arm(input logic ring, input logic [15:0] skip, input logic [7:0] decim);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    cfg_arm       = 1'b1;
    cfg_ring      = ring;
    cfg_skip      = skip;
    cfg_decim     = decim;
    idle();
  endtask

  task automatic send_frame(input int v);
    for (int b = 0; b < FB; b++) beat(bdata(v), buser(v), b == FB - 1);
    idle();
  endtask

  // ramp stream joining mid-frame at beat 3: tlast lands on i = 4, 12, 20, ...
  task automatic send_ramp(input int n, input bit thr);
    for (int i = 0; i < n; i++) begin
      if (thr) repeat ($urandom_range(0, 1)) idle();
      beat(bdata(i), buser(i), (i % 8) == 4);
    end
    idle();
  endtask

  task automatic read(input int a, output logic [TU+DW-1:0] q);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    rd_en   = 1'b1;
    rd_addr = AW'(a);
    @(negedge clk);
    rd_en = 1'b0;
    q = {rd_user, rd_data};
  endtask

  task automatic check_ramp_mem(input string tag);
    logic [TU+DW-1:0] q;
    for (int a = 0; a < FB * FR; a++) begin
      read(a, q);
      check($sformatf("%s_mem%0d", tag, a), q, {buser(a + 5), bdata(a + 5)});
    end
  endtask

  task automatic check_slot(input string tag, input int slot, input int v);
    logic [TU+DW-1:0] q;
    read(slot * FB, q);
    check($sformatf("%s_first", tag), q, {buser(v), bdata(v)});
    read(slot * FB + FB - 1, q);
    check($sformatf("%s_last", tag), q, {buser(v), bdata(v)});
  endtask

  initial begin
    logic [TU+DW-1:0] q;
    rst_n = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = '0;
    cfg_arm = 1'b0; cfg_stop = 1'b0; cfg_ring = 1'b0; cfg_skip = '0; cfg_decim = '0;
    rd_en = 1'b0; rd_addr = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tready", s_axis_tready, 1'b0);
    check_status("rst_status", 0, 0, 0, 0, 16'd0);
    check("rst_rdvalid", {rd_valid, rd_data, rd_user}, '0);
    rst_n = 1'b1;
    #1 check("rel_tready_before_clk", s_axis_tready, 1'b0);
    @(negedge clk);
    check("rel_tready", s_axis_tready, 1'b1);

    // one-shot basic
    arm(1'b0, 16'd0, 8'd0);
    check_status("arm_busy", 1, 0, 0, 0, 16'd0);
    for (int i = 0; i < 13; i++) beat(bdata(i), buser(i), (i % 8) == 4);
    idle();
    check_status("basic_one_frame", 1, 0, 0, 0, 16'd1);
    for (int i = 13; i < 21; i++) beat(bdata(i), buser(i), (i % 8) == 4);
    idle();
    check_status("basic_done", 0, 1, 1, 0, 16'd2);
    send_frame(777);
    check_status("basic_done_ignores", 0, 1, 1, 0, 16'd2);
    read(0, q);
    check("rd_valid_latency", rd_valid, 1'b1);
    check("rd_first", q, {buser(5), bdata(5)});
    idle();
    check("rd_valid_drop", rd_valid, 1'b0);
    check("rd_hold", {rd_user, rd_data}, {buser(5), bdata(5)});
    check_ramp_mem("basic");

    // skip + decimate
    arm(1'b0, 16'd3, 8'd1);
    beat(bdata(99), buser(99), 1'b1);
    for (int n = 0; n < 6; n++) send_frame(n);
    check_status("skipdec_done", 0, 1, 1, 0, 16'd2);
    check_slot("skipdec_slot0", 0, 3);
    check_slot("skipdec_slot1", 1, 5);

    // length error: early tlast at beat 5
    arm(1'b0, 16'd0, 8'd0);
    check_status("arm_clears", 1, 0, 0, 0, 16'd0);
    beat(bdata(99), buser(99), 1'b1);
    for (int b = 0; b < 6; b++) beat(bdata(50), buser(50), b == 5);
    idle();
    check_status("lenerr_flag", 1, 0, 0, 1, 16'd0);
    send_frame(1);
    send_frame(2);
    check_status("lenerr_done", 0, 1, 1, 1, 16'd2);
    check_slot("lenerr_slot0", 0, 1);
    check_slot("lenerr_slot1", 1, 2);

    // ring mode with stop mid-frame 5
    arm(1'b1, 16'd0, 8'd0);
    beat(bdata(99), buser(99), 1'b1);
    send_frame(0);
    check_status("ring_f0", 1, 0, 0, 0, 16'd1);
    send_frame(1);
    check_status("ring_f1_full", 1, 1, 0, 0, 16'd2);
    for (int n = 2; n < 5; n++) send_frame(n);
    check_status("ring_f4", 1, 1, 0, 0, 16'd5);
    for (int b = 0; b < FB; b++) begin
      beat(bdata(5), buser(5), b == FB - 1);
      if (b == 3) cfg_stop = 1'b1;
      if (b == 5) check_status("ring_stop_pending", 1, 1, 0, 0, 16'd5);
    end
    idle();
    check_status("ring_done", 0, 1, 1, 0, 16'd6);
    check_slot("ring_slot0", 0, 4);
    check_slot("ring_slot1", 1, 5);

    // throttled input
    arm(1'b0, 16'd0, 8'd0);
    mon_en = 1'b1;
    send_ramp(21, 1'b1);
    mon_en = 1'b0;
    check_status("thr_done", 0, 1, 1, 0, 16'd2);
    check("thr_tready_never_low", tready_drop, 1'b0);
    check_ramp_mem("thr");

    // reset mid-capture at beat 10
    arm(1'b0, 16'd0, 8'd0);
    for (int i = 0; i < 10; i++) beat(bdata(i), buser(i), (i % 8) == 4);
    check_status("pre_reset", 1, 0, 0, 0, 16'd0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #1 check_status("mid_reset", 0, 0, 0, 0, 16'd0);
    check("mid_reset_tready", s_axis_tready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    send_ramp(21, 1'b0);
    check_status("no_capture_unarmed", 0, 0, 0, 0, 16'd0);
    arm(1'b0, 16'd0, 8'd0);
    send_ramp(21, 1'b0);
    check_status("rearm_done", 0, 1, 1, 0, 16'd2);
    check_ramp_mem("rearm");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parallel_axis_frame_capture.md
Name: parallel_axis_frame_capture

Overview:
- Multi-frame capture sink for SAMP_PER_CLK-wide AXIS sample/spectrum streams (ADC model output, parallel FFT output).
- Parametrised successor to the fixed-depth capture VIP. Adds:
  - tlast frame alignment and frame-length checking
  - frame skip and decimation
  - one-shot or ring (continuous) mode
  - a synchronous readback port, so benches and on-chip debug read captures without hierarchical access.

Parameters:
- SAMP_PER_CLK, 2, samples per beat.
- SAMP_WIDTH, 32, bits per sample (packed re/im).
- TUSER, 8, tuser width, stored alongside each beat.
- FRAME_BEATS, 8, beats per frame (FFT_LEN/SAMP_PER_CLK); must be ≥2.
- FRAMES, 2, frames held in memory.
- Derived: DEPTH = FRAMES*FRAME_BEATS; AW = $clog2(DEPTH).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_tdata  in  SAMP_PER_CLK*SAMP_WIDTH  beat data.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  ready.
- s_axis_tlast  in  1  last beat of frame.
- s_axis_tuser  in  TUSER  sideband.
- cfg_arm  in  1  pulse: clear status and start capture.
- cfg_stop  in  1  pulse: stop ring mode at next frame boundary.
- cfg_ring  in  1  0 = one-shot, 1 = ring; sampled on arm.
- cfg_skip  in  16  frames discarded after sync; sampled on arm.
- cfg_decim  in  8  capture 1 of every cfg_decim+1 frames; sampled on arm.
- rd_en  in  1  read strobe.
- rd_addr  in  AW  beat address.
- rd_data  out  SAMP_PER_CLK*SAMP_WIDTH  read data.
- rd_user  out  TUSER  stored tuser.
- rd_valid  out  1  rd_en delayed 1 cycle.
- busy  out  1  in SYNC/SKIP/CAPTURE.
- full  out  1  DEPTH beats written since arm.
- done  out  1  capture terminated.
- frames_captured  out  16  frames committed since arm (wraps at 2^16).
- err_len  out  1  sticky frame-length error.

Behaviour:
- Reset (async assert, sync deassert):
  - state IDLE.
  - All outputs 0 except s_axis_tready: 0 during reset, 1 from the first clock after release.
  - Write pointer, counters and latched config cleared.
  - Memory contents undefined.
- Handshake:
  - tready = 1 always outside reset (sink never backpressures).
  - A beat is counted only on tvalid && tready; tvalid gaps are transparent.
- States:
  - IDLE: wait for cfg_arm.
  - On arm: latch cfg_*; clear full, done, err_len, frames_captured, write pointer; go to SYNC.
  - SYNC: discard beats until a beat with tlast; on that beat, go to SKIP if skip count > 0, else to CAPTURE. The frame-beat counter starts at 0 on the next beat.
  - SKIP: discard whole frames (counted by tlast) until cfg_skip frames have passed, then go to CAPTURE.
  - CAPTURE: frames are numbered from 0 on entry. A frame is written only when (frame index mod (cfg_decim+1)) == 0; other frames are counted and discarded.
    - Written frame: each beat goes to mem[wptr] (tdata, tuser); wptr increments.
    - On the committing tlast (beat FRAME_BEATS-1), frames_captured increments.
    - One-shot: after FRAMES commits → DONE.
    - Ring: wptr wraps DEPTH-1 → 0. full sets on the first wrap and stays set.
  - DONE: done = 1, busy = 0; beats ignored; cfg_arm restarts.
- Length check, active in SKIP and CAPTURE:
  - Error conditions: tlast at beat < FRAME_BEATS-1, or no tlast at beat FRAME_BEATS-1.
  - On error: err_len sets; wptr rewinds to the start of the current frame slot; the frame is not counted.
  - Early tlast: the next beat is treated as a frame start in the same state.
  - Missing tlast: go to SYNC.
- cfg_stop in ring mode: finish the current frame (commit or discard), then go to DONE. Ignored in other modes/states.
- Simultaneous events:
  - cfg_arm has priority over cfg_stop and over a same-cycle beat; that beat is discarded.
  - cfg_arm mid-capture restarts cleanly.
- Read port:
  - 1-cycle latency; usable in any state.
  - A same-address write in the read cycle returns old data (read-first).
  - rd_data/rd_user hold their value when rd_en = 0.
- frames_captured and full update on the clock edge after the committing beat.

Test Plan:
- One-shot basic:
  - Setup: FRAME_BEATS=8, FRAMES=2, skip=0, decim=0. Ramp data, tlast every 8 beats; stream starts mid-frame at beat 3.
  - Required: first 5 beats discarded; mem[0..15] = beats 5..20; full=1, done=1, frames_captured=2, err_len=0; rd_data valid 1 cycle after rd_en.
- Skip + decimate:
  - Setup: skip=3, decim=1, frame n carries constant n (frames after sync, 0-based).
  - Required: slot 0 holds 3, slot 1 holds 5; frames_captured=2.
- Length error:
  - Setup: tlast at beat 5 of the first frame after sync.
  - Required: err_len=1; slot 0 holds the following correct frame; frames_captured=2 at done.
- Ring mode:
  - Setup: 5 frames, values 0..4, then cfg_stop mid-frame 5.
  - Required: frame 5 completes; slot 0 = 4, slot 1 = 5 (written by frame 5 before stop took effect); full=1; frames_captured=6; done=1.
- Throttled input:
  - Setup: 50% random tvalid.
  - Required: memory identical to the one-shot basic case; tready never 0.
- Reset mid-capture:
  - Setup: rst_n low at beat 10.
  - Required: busy/full/done/frames_captured=0 immediately; after release no capture until cfg_arm; after re-arm, behaviour matches the one-shot basic case.
